// File: rtl/frog_position_ctrl.sv
// frog_position_ctrl: debounces the four buttons and moves the frog on the grid once per frame,
// handling hit-respawn, the top-row win and a saturating score.
module frog_position_ctrl #(
    parameter int DEBOUNCE_CLKS = 250000,
    parameter int GRID_COLS     = 20,
    parameter int GRID_ROWS     = 15,
    parameter int START_COL     = 10,
    parameter int START_ROW     = 14,
    parameter int WIN_FRAMES    = 60
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Up,
    input  logic       i_Down,
    input  logic       i_Left,
    input  logic       i_Right,
    input  logic       i_Frame_Tick,
    input  logic       i_Hit,
    output logic [4:0] o_Frog_Col,
    output logic [3:0] o_Frog_Row,
    output logic       o_Win,
    output logic [7:0] o_Score
);
    localparam int CW = DEBOUNCE_CLKS > 1 ? $clog2(DEBOUNCE_CLKS) : 1;
    localparam int FW = WIN_FRAMES > 1 ? $clog2(WIN_FRAMES) : 1;
    localparam logic [4:0] START_C = 5'(START_COL);
    localparam logic [3:0] START_R = 4'(START_ROW);

    typedef enum logic [2:0] {MV_NONE, MV_UP, MV_DOWN, MV_LEFT, MV_RIGHT} move_t;
    typedef enum logic {S_PLAY, S_WIN} state_t;

    logic [3:0] raw, sync1, sync2, press;

    assign raw = {i_Right, i_Left, i_Down, i_Up};

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // press pulses in the same cycle the stable bit rises, so releases never produce one
    for (genvar b = 0; b < 4; b++) begin : g_btn
        logic [CW-1:0] cnt;
        logic          stable;
        logic          pulse;
        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                cnt    <= '0;
                stable <= 1'b0;
                pulse  <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (sync2[b] == stable)
                    cnt <= '0;
                else if (cnt == CW'(DEBOUNCE_CLKS - 1)) begin
                    cnt    <= '0;
                    stable <= sync2[b];
                    pulse  <= sync2[b];
                end else
                    cnt <= cnt + 1'b1;
            end
        end
        assign press[b] = pulse;
    end

    state_t        state, state_n;
    move_t         pend, pend_n, ev;
    logic [4:0]    col, col_n, mcol;
    logic [3:0]    row, row_n, mrow;
    logic [7:0]    score, score_n;
    logic [FW-1:0] fcnt, fcnt_n;

    assign ev = press[0] ? MV_UP : press[1] ? MV_DOWN : press[2] ? MV_LEFT : press[3] ? MV_RIGHT : MV_NONE;

    // bounds are tested before the step, so the unsigned coordinates never wrap
    assign mrow = (pend == MV_UP && row != '0) ? row - 4'd1 :
                  (pend == MV_DOWN && row != 4'(GRID_ROWS - 1)) ? row + 4'd1 : row;
    assign mcol = (pend == MV_LEFT && col != '0) ? col - 5'd1 :
                  (pend == MV_RIGHT && col != 5'(GRID_COLS - 1)) ? col + 5'd1 : col;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= S_PLAY;
            pend  <= MV_NONE;
            col   <= START_C;
            row   <= START_R;
            score <= '0;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            col   <= col_n;
            row   <= row_n;
            score <= score_n;
            fcnt  <= fcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = pend;
        col_n   = col;
        row_n   = row;
        score_n = score;
        fcnt_n  = fcnt;
        if (state == S_PLAY) begin
            if (i_Frame_Tick) begin
                col_n  = i_Hit ? START_C : mcol;
                row_n  = i_Hit ? START_R : mrow;
                pend_n = ev;
                if (!i_Hit && mrow == '0) begin
                    state_n = S_WIN;
                    pend_n  = MV_NONE;
                    score_n = (score == 8'hFF) ? score : score + 8'd1;
                    fcnt_n  = '0;
                end
            end else if (pend == MV_NONE)
                pend_n = ev;
        end else begin
            pend_n = MV_NONE;
            if (i_Frame_Tick && fcnt == FW'(WIN_FRAMES - 1)) begin
                state_n = S_PLAY;
                col_n   = START_C;
                row_n   = START_R;
            end else if (i_Frame_Tick)
                fcnt_n = fcnt + 1'b1;
        end
    end

    assign o_Frog_Col = col;
    assign o_Frog_Row = row;
    assign o_Win      = (state == S_WIN);
    assign o_Score    = score;
endmodule

// File: tb/tb_frog_position_ctrl.sv
// tb_frog_position_ctrl: directed and random button/tick stimulus; a reference model queues the
// expected outputs after each frame tick and a monitor checks them every cycle.
module tb_frog_position_ctrl;
    localparam int DB = 4;
    localparam int WF = 3;
    localparam int SC = 10;
    localparam int SR = 14;
    localparam int NC = 20;
    localparam int NR = 15;

    typedef struct packed {
        logic [4:0] col;
        logic [3:0] row;
        logic       win;
        logic [7:0] score;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] btn = '0;
    logic       tick = 1'b0;
    logic       hit = 1'b0;
    logic [4:0] col;
    logic [3:0] row;
    logic       win;
    logic [7:0] score;

    int   vectors = 0;
    int   errs = 0;
    int   edge_no = 0;
    exp_t q[$];
    exp_t cur;
    logic tick_seen;

    // reference model state; m_left counts frame ticks still to spend in WIN (0 = playing)
    int m_col, m_row, m_score, m_pend, m_left;
    int hold[4];
    int arrive[4];
    int dc[5] = '{0, 0, 0, -1, 1};
    int dr[5] = '{0, -1, 1, 0, 0};

    frog_position_ctrl #(.DEBOUNCE_CLKS(DB), .WIN_FRAMES(WF)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n),
        .i_Up(btn[0]), .i_Down(btn[1]), .i_Left(btn[2]), .i_Right(btn[3]),
        .i_Frame_Tick(tick), .i_Hit(hit),
        .o_Frog_Col(col), .o_Frog_Row(row), .o_Win(win), .o_Score(score)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) tick_seen <= 1'b0;
        else tick_seen <= tick;

    always @(negedge clk) begin
        if (tick_seen) begin
            if (q.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL scoreboard_underflow: tick seen with no expectation queued");
            end else
                cur = q.pop_front();
        end
        vectors++;
        if ({col, row, win, score} !== cur) begin
            errs++;
            $display("FAIL monitor t=%0t: got col=%0d row=%0d win=%0d score=%0d, want col=%0d row=%0d win=%0d score=%0d",
                     $time, col, row, win, score, cur.col, cur.row, cur.win, cur.score);
        end
    end

    task automatic reset_model();
        m_col = SC; m_row = SR; m_score = 0; m_pend = 0; m_left = 0;
        for (int i = 0; i < 4; i++) begin
            hold[i] = 0;
            arrive[i] = -1;
        end
        cur = '{col: 5'(SC), row: 4'(SR), win: 1'b0, score: 8'd0};
        q.delete();
    endtask

    // one clock of stimulus; a clean press reaches the move logic 3 edges after its DB-th high sample
    task automatic step(input logic [3:0] b, input logic t, input logic h);
        int   n, ev, nc, nr;
        exp_t e;
        n = edge_no + 1;
        btn = b; tick = t; hit = h;
        ev = 0;
        for (int i = 0; i < 4; i++) begin
            if (arrive[i] == n && ev == 0) ev = i + 1;
            hold[i] = b[i] ? hold[i] + 1 : 0;
            if (hold[i] == DB) arrive[i] = n + 3;
        end
        if (m_left == 0) begin
            if (t) begin
                if (h) begin
                    m_col = SC; m_row = SR;
                end else begin
                    nc = m_col + dc[m_pend];
                    nr = m_row + dr[m_pend];
                    if (nc >= 0 && nc < NC) m_col = nc;
                    if (nr >= 0 && nr < NR) m_row = nr;
                end
                m_pend = ev;
                if (m_row == 0) begin
                    m_left = WF;
                    m_score = m_score < 255 ? m_score + 1 : 255;
                    m_pend = 0;
                end
            end else if (m_pend == 0)
                m_pend = ev;
        end else if (t) begin
            m_left--;
            if (m_left == 0) begin
                m_col = SC; m_row = SR;
            end
        end
        if (t) begin
            e.col = 5'(m_col); e.row = 4'(m_row); e.win = (m_left != 0); e.score = 8'(m_score);
            q.push_back(e);
        end
        @(posedge clk);
        edge_no = n;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'b0, 1'b0, 1'b0);
    endtask

    task automatic tick1(input logic h);
        step(4'b0, 1'b1, h);
    endtask

    task automatic press(input logic [3:0] m, input int len);
        repeat (len) step(m, 1'b0, 1'b0);
        idle(DB + 2);
    endtask

    task automatic cross_up();
        repeat (14) begin
            press(4'b0001, DB);
            tick1(1'b0);
        end
    endtask

    task automatic win_out();
        repeat (WF) begin
            idle(1);
            tick1(1'b0);
        end
    endtask

    task automatic chk(input string nm, input int c, input int r, input int w, input int s);
        vectors++;
        if (col !== 5'(c) || row !== 4'(r) || win !== 1'(w) || score !== 8'(s)) begin
            errs++;
            $display("FAIL %s: got col=%0d row=%0d win=%0d score=%0d, want col=%0d row=%0d win=%0d score=%0d",
                     nm, col, row, win, score, c, r, w, s);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reset_model();
        #1;
        chk("async_reset", SC, SR, 0, 0);
        @(posedge clk);
        edge_no++;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        reset_model();
        #2 rst_n = 1'b0;
        #1 chk("reset_state", SC, SR, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (5) begin
            idle(3);
            tick1(1'b0);
            chk("idle_tick", SC, SR, 0, 0);
        end

        press(4'b0001, 10);
        tick1(1'b0);
        chk("up_press", SC, 13, 0, 0);
        press(4'b0100, DB - 1);
        tick1(1'b0);
        chk("left_glitch", SC, 13, 0, 0);

        press(4'b1100, DB);
        tick1(1'b0);
        chk("left_right_priority", 9, 13, 0, 0);
        tick1(1'b1);
        chk("hit_respawn", SC, SR, 0, 0);
        press(4'b0010, DB);
        tick1(1'b0);
        chk("down_clamp", SC, SR, 0, 0);

        cross_up();
        chk("first_win", SC, 0, 1, 1);
        for (int i = 1; i <= WF; i++) begin
            press(4'b0101, DB);
            tick1(1'b1);
            if (i < WF) chk("win_hold", SC, 0, 1, 1);
        end
        chk("win_respawn", SC, SR, 0, 1);
        idle(2);
        tick1(1'b0);
        chk("no_carry_from_win", SC, SR, 0, 1);

        press(4'b0001, DB);
        tick1(1'b0);
        chk("up_before_hit", SC, 13, 0, 1);
        press(4'b1000, DB);
        tick1(1'b1);
        chk("hit_over_right", SC, SR, 0, 1);
        idle(2);
        tick1(1'b0);
        chk("pending_cleared", SC, SR, 0, 1);

        repeat (3) begin
            cross_up();
            win_out();
        end
        cross_up();
        chk("win_score5", SC, 0, 1, 5);
        do_reset();
        idle(2);
        tick1(1'b0);
        chk("after_reset_tick", SC, SR, 0, 0);

        begin
            int         hl[4], gp[4], fl;
            logic [3:0] b;
            logic       t, h;
            for (int i = 0; i < 4; i++) begin
                hl[i] = 0;
                gp[i] = 0;
            end
            fl = $urandom_range(3, 30);
            repeat (3000) begin
                for (int i = 0; i < 4; i++) begin
                    if (hl[i] == 0) begin
                        gp[i]++;
                        if (gp[i] > DB + 2 && $urandom_range(0, 11) == 0) begin
                            hl[i] = $urandom_range(1, DB + 3);
                            gp[i] = 0;
                        end
                    end
                    b[i] = (hl[i] != 0);
                    if (hl[i] != 0) hl[i]--;
                end
                fl--;
                t = (fl == 0);
                if (t) fl = $urandom_range(3, 30);
                h = t ? ($urandom_range(0, 4) == 0) : 1'($urandom_range(0, 1));
                step(b, t, h);
            end
        end

        idle(DB + 6);
        repeat (WF) begin
            idle(1);
            tick1(1'b1);
        end
        chk("normalised", SC, SR, 0, m_score);

        repeat (256) begin
            cross_up();
            win_out();
        end
        chk("score_saturated", SC, SR, 0, 255);

        idle(3);
        vectors++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL queue_drain: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/frog_position_ctrl.md
Name: frog_position_ctrl

Overview:
- Upstream of the frog drawer. Turns the four raw Go Board push-buttons into a frog position on the 20x15 grid of 32x32 cells.
- Debounces each button and queues one move per frame.
- Applies the queued move only on the frame tick, so the drawer never sees the position change mid-frame.
- Handles hit-reset, the win condition on reaching the top row, and a saturating score.

Parameters:
- DEBOUNCE_CLKS, 250000, stable-input cycles needed before a button change is accepted (10 ms at 25 MHz).
- GRID_COLS, 20, number of grid columns.
- GRID_ROWS, 15, number of grid rows.
- START_COL, 10, frog column after reset, hit or win.
- START_ROW, 14, frog row after reset, hit or win (bottom row).
- WIN_FRAMES, 60, frame ticks spent in WIN before the frog respawns.

Ports:
- i_Clk  in  1  pixel clock (25 MHz).
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Up  in  1  raw button, active-high, asynchronous to i_Clk.
- i_Down  in  1  raw button, same as i_Up.
- i_Left  in  1  raw button, same as i_Up.
- i_Right  in  1  raw button, same as i_Up.
- i_Frame_Tick  in  1  one-cycle pulse at the start of vertical blank (v_counter == 480, h_counter == 0).
- i_Hit  in  1  collision level from the hazard logic; sampled only on i_Frame_Tick.
- o_Frog_Col  out  5  current frog column, 0..GRID_COLS-1.
- o_Frog_Row  out  4  current frog row, 0..GRID_ROWS-1; 0 is the top row.
- o_Win  out  1  high for the whole WIN state.
- o_Score  out  8  count of completed crossings, saturates at 255.

Behaviour:
- Reset (asynchronous, i_Rst_L = 0):
  - o_Frog_Col = START_COL, o_Frog_Row = START_ROW, o_Win = 0, o_Score = 0.
  - State = PLAY; all debounce counters, stable bits and the pending-move register cleared.
  - Reset asserted mid-debounce or during WIN returns everything to these values; no partial move survives.
- Input path, per button:
  - 2-flop synchronizer, then a counter of width clog2(DEBOUNCE_CLKS).
  - Counter clears whenever the synced bit equals the stable bit; otherwise it increments.
  - At DEBOUNCE_CLKS-1 the stable bit takes the synced value and the counter clears.
- Press event: one-cycle pulse on a rising edge of a stable bit. Latency from a clean raw edge to the event is 2 + DEBOUNCE_CLKS cycles; releases generate nothing.
- Pending move: a 3-bit register holding NONE, UP, DOWN, LEFT or RIGHT.
  - Only the first event after the last frame tick is latched; later events are dropped until the next tick.
  - If several events arrive in the same cycle, priority is UP > DOWN > LEFT > RIGHT.
  - If an event coincides with i_Frame_Tick, the tick consumes the old pending value and the new event is latched for the next frame.
- PLAY state, on i_Frame_Tick:
  - If i_Hit = 1: position goes to START, pending cleared, no score change. A hit overrides any pending move.
  - Else apply the pending move with clamping, no wrap-around:
    - UP at row 0 is impossible, since row 0 causes WIN.
    - DOWN at GRID_ROWS-1, LEFT at col 0 and RIGHT at GRID_COLS-1 leave the position unchanged.
  - Clear pending after applying it.
  - If the new row is 0: go to WIN, o_Win = 1 from the next cycle, o_Score += 1 (saturating at 255), frame counter cleared.
- WIN state:
  - Position held at the winning cell.
  - Press events are ignored and pending is held at NONE; i_Hit is ignored.
  - Each i_Frame_Tick increments the frame counter.
  - On the tick where the counter reaches WIN_FRAMES-1: position goes to START, o_Win = 0, state returns to PLAY.
- Output timing: all outputs are registered and change only in the cycle after i_Frame_Tick (or on reset), so they are stable through the whole active frame.
- Arithmetic: coordinates are unsigned; bounds are checked before the add or subtract, so no underflow can occur.

Test Plan (bench uses DEBOUNCE_CLKS = 4, WIN_FRAMES = 3):
- Reset release, no input, 5 ticks -> col 10, row 14, o_Win 0, o_Score 0 throughout.
- Clean i_Up pulse held 10 cycles, then a tick -> row 13 in the cycle after the tick; a 3-cycle glitch on i_Left produces no move.
- i_Left and i_Right rise in the same cycle, then a tick -> col 9; pressing i_Down at row 14 then ticking leaves row 14.
- 14 Up presses, each separated by a tick -> at row 0 o_Win = 1 and o_Score = 1; presses ignored for 3 ticks; then col 10, row 14, o_Win 0.
- Pending Right with i_Hit = 1 at the tick -> START position and pending cleared; the next tick without a press causes no move.
- i_Rst_L pulsed low during WIN with o_Score = 5 -> immediately col 10, row 14, o_Win 0, o_Score 0.
